// File: rtl/mul_dispatcher_pkg.sv
// mul_dispatcher_pkg: shared constants and FSM encoding for the multiplier dispatcher.
//   SIZE_MUL             default operand width (product is 2*SIZE_MUL)
//   DEPTH_DEFAULT        default operand FIFO depth
//   MUL_TIMEOUT_DEFAULT  default ISSUE timeout in cycles (used when MUL_TIMEOUT_EN is defined)
//   state_t              dispatcher FSM states
package mul_dispatcher_pkg;

   localparam int SIZE_MUL            = 32;
   localparam int DEPTH_DEFAULT       = 4;
   localparam int MUL_TIMEOUT_DEFAULT = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

endpackage

// File: rtl/mul_op_fifo.sv
// mul_op_fifo: DEPTH x WIDTH register FIFO holding packed operand pairs.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push, din    write request and data; ignored while full (even with a same-cycle pop)
//   pop, dout    read request and head-of-queue data (dout valid while !empty)
//   full, empty  occupancy flags
//   count        number of stored entries, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two (>=2) so the pointers wrap by natural overflow.
module mul_op_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mul_dispatcher.sv
// mul_dispatcher: feeds operand pairs to the shift-add multiplier core one at a time
// and holds each product for a valid/ready consumer.
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b  operand producer (in_ready = FIFO not full)
//   mul_a/mul_b                  operands to the core, stable from ISSUE until the next pop
//   mul_valid_data/mul_ack       request and product-accepted acknowledge to the core
//   mul_prod/mul_done/mul_ret_ack core product, Done_Flag and return-acknowledge
//   res_valid/res_ready/res_prod product consumer
//   busy                         FSM not idle or FIFO non-empty
//   err                          sticky ISSUE timeout flag (only with MUL_TIMEOUT_EN)
// Build option: define MUL_TIMEOUT_EN to add the ISSUE timeout counter and the err port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operand pair; pops the FIFO head into mul_a/mul_b
// ISSUE | mul_valid_data high; waiting for mul_done and a free result slot
// ACK   | mul_ack high; waiting for mul_ret_ack from the core
module mul_dispatcher
   import mul_dispatcher_pkg::*;
#(
   parameter int SIZE  = SIZE_MUL,
   parameter int DEPTH = DEPTH_DEFAULT
`ifdef MUL_TIMEOUT_EN
   ,
   parameter int TIMEOUT = MUL_TIMEOUT_DEFAULT
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   in_a,
   input  logic [SIZE-1:0]   in_b,
   output logic [SIZE-1:0]   mul_a,
   output logic [SIZE-1:0]   mul_b,
   output logic              mul_valid_data,
   output logic              mul_ack,
   input  logic [2*SIZE-1:0] mul_prod,
   input  logic              mul_done,
   input  logic              mul_ret_ack,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [2*SIZE-1:0] res_prod,
   output logic              busy
`ifdef MUL_TIMEOUT_EN
   ,
   output logic              err
`endif
);

   state_t                  state_q;
   state_t                  state_d;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic [2*SIZE-1:0]       fifo_head;
   logic                    pop;
   logic                    capture;
   logic                    slot_free;

   assign in_ready = !fifo_full;

   mul_op_fifo #(
      .WIDTH (2*SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid && in_ready),
      .din   ({in_a, in_b}),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A held product frees its slot in the same cycle the consumer takes it,
   // so a waiting done can refill without a bubble.
   assign slot_free = !res_valid || res_ready;

`ifdef MUL_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_cnt;
   logic          drop;

   // Down-counter loaded on entry to ISSUE; terminal count 0 marks the
   // TIMEOUT-th cycle spent waiting for mul_done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= '0;
         err     <= 1'b0;
      end else begin
         if (pop) begin
            tmo_cnt <= TMO_LOAD;
         end else if (state_q == ST_ISSUE && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
         end
         if (drop) begin
            err <= 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      capture = 1'b0;
`ifdef MUL_TIMEOUT_EN
      drop    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // With the slot occupied the core keeps Done_Flag high, so we just wait.
            if (mul_done && slot_free) begin
               capture = 1'b1;
               state_d = ST_ACK;
            end
`ifdef MUL_TIMEOUT_EN
            else if (!mul_done && tmo_cnt == '0) begin
               drop    = 1'b1;
               state_d = ST_ACK;
            end
`endif
         end
         ST_ACK: begin
            if (mul_ret_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign mul_valid_data = (state_q == ST_ISSUE);
   assign mul_ack        = (state_q == ST_ACK);
   assign busy           = (state_q != ST_IDLE) || (fifo_count != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_a <= '0;
         mul_b <= '0;
      end else if (pop) begin
         mul_a <= fifo_head[2*SIZE-1:SIZE];
         mul_b <= fifo_head[SIZE-1:0];
      end
   end

   // Refill wins over consume when both happen in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_valid <= 1'b0;
         res_prod  <= '0;
      end else if (capture) begin
         res_valid <= 1'b1;
         res_prod  <= mul_prod;
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mul_dispatcher.sv
// tb_mul_dispatcher: scoreboard bench for mul_dispatcher paired with a behavioural
// shift-add core model (fixed latency, holds done until mul_ack, answers with ret_ack).
// Define MUL_TIMEOUT_EN to also exercise the ISSUE timeout with a core that never finishes.
module tb_mul_dispatcher;

   localparam int SIZE = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [SIZE-1:0]   in_a = '0;
   logic [SIZE-1:0]   in_b = '0;
   logic [SIZE-1:0]   mul_a;
   logic [SIZE-1:0]   mul_b;
   logic              mul_valid_data;
   logic              mul_ack;
   logic [2*SIZE-1:0] mul_prod;
   logic              mul_done;
   logic              mul_ret_ack;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [2*SIZE-1:0] res_prod;
   logic              busy;
`ifdef MUL_TIMEOUT_EN
   logic              err;
`endif

   int total = 0;
   int bad   = 0;
   logic [2*SIZE-1:0] sb_q[$];

   always #5 clk = ~clk;

   mul_dispatcher #(.SIZE(SIZE), .DEPTH(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_a           (in_a),
      .in_b           (in_b),
      .mul_a          (mul_a),
      .mul_b          (mul_b),
      .mul_valid_data (mul_valid_data),
      .mul_ack        (mul_ack),
      .mul_prod       (mul_prod),
      .mul_done       (mul_done),
      .mul_ret_ack    (mul_ret_ack),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_prod       (res_prod),
      .busy           (busy)
`ifdef MUL_TIMEOUT_EN
      ,
      .err            (err)
`endif
   );

   // ---------------- core model ----------------
   typedef enum logic [1:0] {C_IDLE, C_BUSY, C_DONE, C_RET} cst_t;
   cst_t            cst;
   logic [SIZE-1:0] lat_a, lat_b;
   int              core_cnt;
   logic            core_hang = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         cst         <= C_IDLE;
         mul_done    <= 1'b0;
         mul_ret_ack <= 1'b0;
         mul_prod    <= '0;
         lat_a       <= '0;
         lat_b       <= '0;
         core_cnt    <= 0;
      end else begin
         case (cst)
            C_IDLE: if (mul_valid_data) begin
               lat_a    <= mul_a;
               lat_b    <= mul_b;
               core_cnt <= 3;
               cst      <= C_BUSY;
            end
            C_BUSY: begin
               if (mul_ack) begin
                  mul_ret_ack <= 1'b1;
                  cst         <= C_RET;
               end else if (!core_hang) begin
                  if (core_cnt == 0) begin
                     mul_done <= 1'b1;
                     mul_prod <= {32'b0, lat_a} * {32'b0, lat_b};
                     cst      <= C_DONE;
                  end else begin
                     core_cnt <= core_cnt - 1;
                  end
               end
            end
            C_DONE: if (mul_ack) begin
               mul_done    <= 1'b0;
               mul_ret_ack <= 1'b1;
               cst         <= C_RET;
            end
            C_RET: if (!mul_ack) begin
               mul_ret_ack <= 1'b0;
               cst         <= C_IDLE;
            end
            default: cst <= C_IDLE;
         endcase
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic try_push(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input bit track, output bit ok);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      ok       = in_ready;
      @(posedge clk);
      if (ok && track) sb_q.push_back(exp);
   endtask

   task automatic in_idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input bit track);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) try_push(a, b, exp, track, ok);
      in_idle();
      if (!ok) check("push_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_valid_data();
      int n;
      n = 0;
      while (!mul_valid_data && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_valid_data", 64'(mul_valid_data), 64'd1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy || res_valid) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_left", 64'(sb_q.size()), 64'd0);
      check("drain_busy", 64'(busy), 64'd0);
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk); #2;
         if (reset && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL res_unexpected actual=%h required=none", res_prod);
            end else begin
               exp = sb_q.pop_front();
               check("res_prod", res_prod, exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   logic [31:0] va [4] = '{32'd0,  32'd3,  32'd100,   32'd12345};
   logic [31:0] vb [4] = '{32'd123, 32'd5, 32'd200,   32'd1000};
   logic [63:0] ve [4] = '{64'd0,  64'd15, 64'd20000, 64'd12345000};

   initial begin
      bit ok;
      int n;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_valid_data", 64'(mul_valid_data), 64'd0);
      check("rst_ack", 64'(mul_ack), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_res_prod", res_prod, 64'd0);
`ifdef MUL_TIMEOUT_EN
      check("rst_err", 64'(err), 64'd0);
`endif
      @(negedge clk);
      reset = 1'b1;

      // 6*7: two-cycle issue latency, result held (res_ready low)
      try_push(32'd6, 32'd7, 64'd42, 1'b1, ok);
      in_idle();
      check("t1_accept", 64'(ok), 64'd1);
      check("t1_valid_early", 64'(mul_valid_data), 64'd0);
      @(posedge clk); #1;
      check("t1_valid_lat", 64'(mul_valid_data), 64'd1);
      check("t1_mul_a", 64'(mul_a), 64'd6);
      check("t1_mul_b", 64'(mul_b), 64'd7);
      n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
      check("t1_res_valid", 64'(res_valid), 64'd1);
      check("t1_res_prod", res_prod, 64'd42);
      check("t1_ack", 64'(mul_ack), 64'd1);
      n = 0;
      while (mul_ack && n < 20) begin @(posedge clk); #1; n++; end
      check("t1_ack_drop", 64'(mul_ack), 64'd0);

      // max operands; slot occupied so the FSM parks in ISSUE
      push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
      repeat (12) @(posedge clk);
      #1;
      check("t5_stall_issue", 64'(mul_valid_data), 64'd1);
      check("t5_stall_ack", 64'(mul_ack), 64'd0);
      check("t5_core_done", 64'(mul_done), 64'd1);

      // fill the FIFO back-to-back, then one more must be refused
      for (int i = 0; i < 4; i++) begin
         try_push(va[i], vb[i], ve[i], 1'b1, ok);
         check("t2_accept", 64'(ok), 64'd1);
      end
      try_push(32'd9, 32'd9, 64'd81, 1'b1, ok);
      in_idle();
      check("t2_full_refuse", 64'(ok), 64'd0);
      check("t2_in_ready", 64'(in_ready), 64'd0);

      // release consumer: the waiting product refills in the same cycle
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk); #1;
      check("t5_refill_valid", 64'(res_valid), 64'd1);
      check("t5_refill_prod", res_prod, 64'hFFFF_FFFE_0000_0001);
      check("t5_refill_ack", 64'(mul_ack), 64'd1);
      wait_drain();

      // reset during ISSUE
      push_pair(32'd2, 32'd3, 64'd6, 1'b0);
      wait_valid_data();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("t6_res_valid", 64'(res_valid), 64'd0);
      check("t6_valid_data", 64'(mul_valid_data), 64'd0);
      check("t6_in_ready", 64'(in_ready), 64'd1);
      check("t6_busy", 64'(busy), 64'd0);
      check("t6_ack", 64'(mul_ack), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      push_pair(32'd7, 32'd8, 64'd56, 1'b1);
      wait_drain();

`ifdef MUL_TIMEOUT_EN
      // core never raises done: abort after TIMEOUT cycles in ISSUE
      core_hang = 1'b1;
      push_pair(32'd1, 32'd1, 64'd1, 1'b0);
      wait_valid_data();
      n = 0;
      while (!err && n < 400) begin @(posedge clk); #1; n++; end
      check("tmo_err", 64'(err), 64'd1);
      check("tmo_cycles", 64'(n), 64'd256);
      check("tmo_res_valid", 64'(res_valid), 64'd0);
      n = 0;
      while (busy && n < 20) begin @(posedge clk); #1; n++; end
      check("tmo_back_idle", 64'(busy), 64'd0);
      check("tmo_sticky", 64'(err), 64'd1);
      core_hang = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("tmo_err_cleared", 64'(err), 64'd0);
      @(negedge clk);
      reset = 1'b1;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("final_queue", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
